// File: rtl/prio_event_encoder_if.sv
// Bundle for the priority event encoder: request/mask/mode inputs, winner handshake and status.
// The master side is the encoder itself; the slave side is the event sources plus the consumer.
interface prio_event_encoder_if #(
  parameter int N          = 8,
  parameter int DROP_CNT_W = 8
);
  localparam int IDXW = $clog2(N);

  logic [N-1:0]          req;
  logic [N-1:0]          mask;
  logic                  mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDXW-1:0]       out_idx;
  logic [N-1:0]          pend;
  logic                  any_pend;
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    input  req, mask, mode, out_ready,
    output out_valid, out_idx, pend, any_pend, drop, drop_cnt
  );

  modport slave (
    output req, mask, mode, out_ready,
    input  out_valid, out_idx, pend, any_pend, drop, drop_cnt
  );
endinterface

// File: rtl/prio_event_encoder.sv
// Sticky event capture with a registered fixed-priority / round-robin winner on valid/ready.
// Also counts events lost because their source was already pending.
module prio_event_encoder #(
  parameter int N          = 8,
  parameter int DROP_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  prio_event_encoder_if.master   bus
);
  localparam int IDXW = $clog2(N);

  logic [N-1:0]          r_pend;
  logic                  r_valid;
  logic [IDXW-1:0]       r_idx;
  logic [IDXW-1:0]       r_ptr;
  logic                  r_drop;
  logic [DROP_CNT_W-1:0] r_cnt;

  logic                  w_hs;
  logic                  w_load;
  logic [N-1:0]          w_clr;
  logic [N-1:0]          w_hold;
  logic [N-1:0]          w_pend_nxt;
  logic [N-1:0]          w_cand;
  logic [N-1:0]          w_lost;
  logic [IDXW-1:0]       w_win;
  logic [IDXW-1:0]       w_ptr_nxt;

  function automatic logic [IDXW-1:0] win_fixed(input logic [N-1:0] c);
    logic [IDXW-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (c[i]) w = IDXW'(i);
    end
    return w;
  endfunction

  // Scan from the far end back toward ptr so the last hit is the first set bit at/after ptr.
  function automatic logic [IDXW-1:0] win_rr(input logic [N-1:0] c, input logic [IDXW-1:0] p);
    logic [IDXW-1:0] w;
    int              j;
    w = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N) j = j - N;
      if (c[j]) w = IDXW'(j);
    end
    return w;
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  always_comb begin
    w_hs   = r_valid & bus.out_ready;
    w_load = ~r_valid | w_hs;
    w_clr  = '0;
    w_hold = '0;
    for (int i = 0; i < N; i++) begin
      w_clr[i]  = w_hs && (r_idx == IDXW'(i));
      w_hold[i] = r_valid && !w_hs && (r_idx == IDXW'(i));
    end
    // A new request on the bit being retired keeps it pending.
    w_pend_nxt = (r_pend & ~w_clr) | bus.req;
    w_cand     = w_pend_nxt & bus.mask & ~w_hold;
    w_lost     = bus.req & r_pend & ~w_clr;
    w_win      = bus.mode ? win_rr(w_cand, r_ptr) : win_fixed(w_cand);
    w_ptr_nxt  = (r_idx == IDXW'(N - 1)) ? '0 : r_idx + IDXW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_drop  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      // The presented index is frozen until accepted, whatever mask/mode/req do meanwhile.
      if (w_load) begin
        r_valid <= |w_cand;
        if (|w_cand) r_idx <= w_win;
      end
      if (w_hs) r_ptr <= w_ptr_nxt;
      r_drop <= |w_lost;
      if (|w_lost) r_cnt <= sat_inc(r_cnt);
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_idx   = r_idx;
  assign bus.pend      = r_pend;
  assign bus.any_pend  = |r_pend;
  assign bus.drop      = r_drop;
  assign bus.drop_cnt  = r_cnt;
endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed bench for prio_event_encoder: expected winners queued at stimulus time, popped on each accept.
module tb_prio_event_encoder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [2:0] sb[$];

  prio_event_encoder_if #(.N(8), .DROP_CNT_W(2)) bus();

  prio_event_encoder #(.N(8), .DROP_CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Before each edge: if a transfer is about to be accepted, compare it with the scoreboard head.
  task automatic step();
    logic [2:0] e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("hs_unexpected", 64'(bus.out_idx), 64'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("accept_idx", 64'(bus.out_idx), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req = 8'hFF;
    bus.mask = 8'hFF;
    bus.mode = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    step();

    // reset release
    rst = 1'b0;
    bus.req = 8'h00;
    chk("rst_pend", 64'(bus.pend), 64'h0);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_cnt", 64'(bus.drop_cnt), 64'h0);
    step();
    chk("rst_valid2", 64'(bus.out_valid), 64'h0);
    chk("rst_anyp", 64'(bus.any_pend), 64'h0);
    chk("rst_drop", 64'(bus.drop), 64'h0);

    // fixed-priority drain
    bus.out_ready = 1'b1;
    bus.req = 8'b0010_0101;
    sb.push_back(3'd5); sb.push_back(3'd2); sb.push_back(3'd0);
    step();
    bus.req = 8'h00;
    chk("fix_first_valid", 64'(bus.out_valid), 64'h1);
    step(); step(); step();
    chk("fix_sb_empty", 64'(sb.size()), 64'h0);
    chk("fix_valid_end", 64'(bus.out_valid), 64'h0);
    chk("fix_pend_end", 64'(bus.pend), 64'h0);

    // backpressure
    bus.out_ready = 1'b0;
    bus.req = 8'h08; sb.push_back(3'd3);
    step();
    bus.req = 8'h40; sb.push_back(3'd6);
    step();
    bus.req = 8'h00;
    chk("bp_valid", 64'(bus.out_valid), 64'h1);
    chk("bp_hold1", 64'(bus.out_idx), 64'd3);
    chk("bp_pend", 64'(bus.pend), 64'h48);
    step();
    chk("bp_hold2", 64'(bus.out_idx), 64'd3);
    bus.out_ready = 1'b1;
    step(); step();
    chk("bp_sb_empty", 64'(sb.size()), 64'h0);
    chk("bp_pend_end", 64'(bus.pend), 64'h0);

    // round-robin wrap from a fresh pointer
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    bus.mode = 1'b1;
    bus.req = 8'hFF;
    for (int i = 0; i < 8; i++) sb.push_back(3'(i));
    step();
    bus.req = 8'h00;
    for (int i = 0; i < 8; i++) step();
    chk("rr_sb_empty", 64'(sb.size()), 64'h0);
    chk("rr_idle", 64'(bus.out_valid), 64'h0);
    bus.req = 8'hFF;
    sb.push_back(3'd0);
    step();
    bus.req = 8'h00;
    chk("rr_rewrap_idx", 64'(bus.out_idx), 64'd0);
    step();
    for (int i = 1; i < 8; i++) sb.push_back(3'(i));
    for (int i = 1; i < 8; i++) step();
    chk("rr_sb_empty2", 64'(sb.size()), 64'h0);
    chk("rr_pend_end", 64'(bus.pend), 64'h0);

    // saturating drop counter (2 bits)
    bus.mode = 1'b0;
    bus.out_ready = 1'b0;
    bus.req = 8'h10; sb.push_back(3'd4);
    step();
    bus.req = 8'h00;
    step();
    chk("drop_none", 64'(bus.drop), 64'h0);
    chk("drop_cnt0", 64'(bus.drop_cnt), 64'h0);
    for (int i = 0; i < 4; i++) begin
      bus.req = 8'h10;
      step();
      bus.req = 8'h00;
      chk("drop_pulse", 64'(bus.drop), 64'h1);
      chk("drop_cnt", 64'(bus.drop_cnt), 64'((i < 3) ? i + 1 : 3));
      step();
      chk("drop_low", 64'(bus.drop), 64'h0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("drop_pend_end", 64'(bus.pend), 64'h0);

    // same-bit request while it is being accepted stays pending, no drop
    bus.req = 8'h08; sb.push_back(3'd3);
    step();
    sb.push_back(3'd3);
    step();
    bus.req = 8'h00;
    chk("rehit_drop", 64'(bus.drop), 64'h0);
    chk("rehit_pend", 64'(bus.pend), 64'h08);
    step();
    chk("rehit_pend_end", 64'(bus.pend), 64'h0);

    // mask keeps bit 7 parked until unmasked
    bus.mask = 8'h7F;
    bus.req = 8'h82; sb.push_back(3'd1);
    step();
    bus.req = 8'h00;
    step();
    chk("mask_valid", 64'(bus.out_valid), 64'h0);
    chk("mask_pend", 64'(bus.pend), 64'h80);
    chk("mask_anyp", 64'(bus.any_pend), 64'h1);
    step();
    chk("mask_still", 64'(bus.out_valid), 64'h0);
    bus.mask = 8'hFF;
    sb.push_back(3'd7);
    step();
    chk("unmask_valid", 64'(bus.out_valid), 64'h1);
    chk("unmask_idx", 64'(bus.out_idx), 64'd7);
    step();
    chk("mask_sb_empty", 64'(sb.size()), 64'h0);
    chk("mask_pend_end", 64'(bus.pend), 64'h0);
    chk("mask_anyp_end", 64'(bus.any_pend), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
